// File: rtl/conv_filter_if.sv
// Pixel stream bus for the 3x3 box-average filter: coordinates plus RGB in,
// filtered RGB out. The master drives pixels, the slave (the filter) answers.
interface conv_filter_if;
  logic        valid;
  logic [7:0]  r_in;
  logic [7:0]  g_in;
  logic [7:0]  b_in;
  logic [10:0] x_in;
  logic [10:0] y_in;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;

  modport master (
    output valid, r_in, g_in, b_in, x_in, y_in,
    input  r_out, g_out, b_out
  );

  modport slave (
    input  valid, r_in, g_in, b_in, x_in, y_in,
    output r_out, g_out, b_out
  );
endinterface

// File: rtl/conv_filter.sv
// Streaming 3x3 box-average filter for RGB video. Each channel keeps two line
// buffers and a two-deep column-sum history; border pixels pass straight through.
module conv_filter #(
  parameter int IMAGE_WIDTH = 640
) (
  input logic         clk,
  input logic         rst,
  conv_filter_if.slave pix
);

  localparam int ADDR_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  logic              in_range;
  logic              full_window;
  logic [ADDR_W-1:0] addr;
  logic [2:0][7:0]   cur;

  assign in_range    = pix.x_in < 11'(IMAGE_WIDTH);
  assign full_window = in_range && (pix.x_in >= 11'd2) && (pix.y_in >= 11'd2);
  // Out-of-range columns read a harmless address; their result is never used.
  assign addr        = in_range ? pix.x_in[ADDR_W-1:0] : '0;
  assign cur         = {pix.r_in, pix.g_in, pix.b_in};

  genvar ch;
  generate
    for (ch = 0; ch < 3; ch++) begin : chan
      logic [7:0]  lb1 [IMAGE_WIDTH];
      logic [7:0]  lb2 [IMAGE_WIDTH];
      logic [9:0]  colsum;
      logic [9:0]  colsum_d1;
      logic [9:0]  colsum_d2;
      logic [11:0] total;
      logic [23:0] prod;
      logic [7:0]  mean;
      logic [7:0]  out_q;

      assign colsum = 10'(cur[ch]) + 10'(lb1[addr]) + 10'(lb2[addr]);
      assign total  = 12'(colsum) + 12'(colsum_d1) + 12'(colsum_d2);
      // Multiply by 7282 then drop 16 bits: exact floor(total/9) for 0..2295.
      assign prod   = 24'(total) * 24'd7282;
      assign mean   = 8'(prod >> 16);

      always_ff @(posedge clk) begin
        if (pix.valid && in_range) begin
          lb2[addr] <= lb1[addr];
          lb1[addr] <= cur[ch];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          colsum_d1 <= '0;
          colsum_d2 <= '0;
          out_q     <= '0;
        end else if (pix.valid) begin
          colsum_d1 <= colsum;
          colsum_d2 <= colsum_d1;
          out_q     <= full_window ? mean : cur[ch];
        end
      end
    end
  endgenerate

  assign pix.r_out = chan[2].out_q;
  assign pix.g_out = chan[1].out_q;
  assign pix.b_out = chan[0].out_q;

endmodule

// File: tb/tb_conv_filter.sv
// Self-checking bench for conv_filter: a frame-image golden model feeds a
// scoreboard queue of expected {r,g,b} words that is popped after every edge.
module tb_conv_filter;

  localparam int W = 50;
  localparam int MAX_ROWS = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  conv_filter_if bus ();

  conv_filter #(.IMAGE_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .pix (bus.slave)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [23:0] exp_q [$];
  logic [7:0]  img   [3][MAX_ROWS][W];
  logic [23:0] last_out;

  // Golden model: remembers the frame and averages the 3x3 window directly.
  function automatic logic [23:0] model_pixel(input int x, input int y,
                                              input logic [7:0] r, input logic [7:0] g,
                                              input logic [7:0] b);
    logic [7:0]  px [3];
    logic [23:0] res;
    int          sum;
    px[0] = r;
    px[1] = g;
    px[2] = b;
    if (x < W)
      for (int c = 0; c < 3; c++) img[c][y][x] = px[c];
    if (x >= 2 && y >= 2 && x < W) begin
      for (int c = 0; c < 3; c++) begin
        sum = 0;
        for (int dy = 0; dy < 3; dy++)
          for (int dx = 0; dx < 3; dx++)
            sum += int'(img[c][y-dy][x-dx]);
        res[(2-c)*8 +: 8] = 8'(sum / 9);
      end
    end else begin
      res = {r, g, b};
    end
    return res;
  endfunction

  task automatic applyStimulus(input int x, input int y, input logic [7:0] r,
                               input logic [7:0] g, input logic [7:0] b);
    bus.valid = 1'b1;
    bus.x_in  = 11'(x);
    bus.y_in  = 11'(y);
    bus.r_in  = r;
    bus.g_in  = g;
    bus.b_in  = b;
    exp_q.push_back(model_pixel(x, y, r, g, b));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [23:0] got;
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    bus.r_in  = 8'h5a;
    bus.g_in  = 8'ha5;
    bus.b_in  = 8'h3c;
    #3;
    got = {bus.r_out, bus.g_out, bus.b_out};
    compared++;
    if (got !== 24'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_initial got=%h want=%h", got, 24'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_out = 24'h0;
  endtask

  task automatic test_border;
    logic [23:0] got, want;
    logic [7:0]  r, g, b;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < W + 3; x++) begin
        r = 8'($urandom);
        g = 8'($urandom);
        b = 8'($urandom);
        applyStimulus(x, y, r, g, b);
        got  = {bus.r_out, bus.g_out, bus.b_out};
        want = exp_q.pop_front();
        if (x < 2 || y < 2 || x >= W) want = {r, g, b};
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("[TB] FAIL border x=%0d y=%0d got=%h want=%h", x, y, got, want);
        end
        last_out = want;
      end
    end
  endtask

  task automatic test_row_gradient;
    logic [23:0] got, want;
    logic [7:0]  v;
    for (int y = 0; y < 3; y++) begin
      v = 8'(10 * (y + 1));
      for (int x = 0; x < W; x++) begin
        applyStimulus(x, y, v, v, v);
        got  = {bus.r_out, bus.g_out, bus.b_out};
        want = exp_q.pop_front();
        if (y == 2 && x >= 2) want = {8'd20, 8'd20, 8'd20};
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("[TB] FAIL gradient x=%0d y=%0d got=%h want=%h", x, y, got, want);
        end
        last_out = want;
      end
    end
  endtask

  // R all 255 (sum 2295), G covers 0..8 (sum 36), B covers 0..7,7 (sum 35).
  task automatic test_exact_division;
    logic [23:0] got, want;
    logic [7:0]  gv, bv;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < W; x++) begin
        gv = 8'((y % 3) * 3 + (x % 3));
        bv = (gv == 8'd8) ? 8'd7 : gv;
        applyStimulus(x, y, 8'd255, gv, bv);
        got  = {bus.r_out, bus.g_out, bus.b_out};
        want = exp_q.pop_front();
        if (y == 2 && x >= 2) want = {8'd255, 8'd4, 8'd3};
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("[TB] FAIL division x=%0d y=%0d got=%h want=%h", x, y, got, want);
        end
        last_out = want;
      end
    end
  endtask

  task automatic test_valid_gating;
    logic [23:0] got, want;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == 3 && x == 20) begin
          for (int k = 0; k < 3; k++) begin
            bus.valid = 1'b0;
            bus.x_in  = 11'(20 + k);
            bus.y_in  = 11'($urandom_range(0, 5));
            bus.r_in  = 8'($urandom);
            bus.g_in  = 8'($urandom);
            bus.b_in  = 8'($urandom);
            @(posedge clk);
            #1;
            got = {bus.r_out, bus.g_out, bus.b_out};
            compared++;
            if (got !== last_out) begin
              mismatched++;
              $display("[TB] FAIL valid_hold k=%0d got=%h want=%h", k, got, last_out);
            end
          end
        end
        applyStimulus(x, y, 8'($urandom), 8'($urandom), 8'($urandom));
        got  = {bus.r_out, bus.g_out, bus.b_out};
        want = exp_q.pop_front();
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("[TB] FAIL valid_gating x=%0d y=%0d got=%h want=%h", x, y, got, want);
        end
        last_out = want;
      end
    end
  endtask

  task automatic test_multi_frame;
    logic [23:0] got, want;
    for (int f = 0; f < 5; f++) begin
      for (int y = 0; y < 5; y++) begin
        for (int x = 0; x < W; x++) begin
          applyStimulus(x, y, 8'($urandom), 8'($urandom), 8'($urandom));
          got  = {bus.r_out, bus.g_out, bus.b_out};
          want = exp_q.pop_front();
          compared++;
          if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL multi_frame f=%0d x=%0d y=%0d got=%h want=%h",
                     f, x, y, got, want);
          end
          last_out = want;
        end
      end
    end
  endtask

  // Reset lands between edges while valid pixels keep streaming.
  task automatic test_reset_midstream;
    logic [23:0] got, want;
    for (int x = 0; x < 10; x++) begin
      applyStimulus(x, 3, 8'($urandom), 8'($urandom), 8'($urandom));
      void'(exp_q.pop_front());
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus.r_out, bus.g_out, bus.b_out};
    compared++;
    if (got !== 24'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_async got=%h want=%h", got, 24'h0);
    end
    for (int k = 0; k < 3; k++) begin
      bus.valid = 1'b1;
      bus.x_in  = 11'(10 + k);
      bus.r_in  = 8'($urandom);
      bus.g_in  = 8'($urandom);
      bus.b_in  = 8'($urandom);
      @(posedge clk);
      #1;
      got = {bus.r_out, bus.g_out, bus.b_out};
      compared++;
      if (got !== 24'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_hold k=%0d got=%h want=%h", k, got, 24'h0);
      end
    end
    bus.valid = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < W; x++) begin
        applyStimulus(x, y, 8'($urandom), 8'($urandom), 8'($urandom));
        got  = {bus.r_out, bus.g_out, bus.b_out};
        want = exp_q.pop_front();
        compared++;
        if (got !== want) begin
          mismatched++;
          $display("[TB] FAIL after_reset x=%0d y=%0d got=%h want=%h", x, y, got, want);
        end
        last_out = want;
      end
    end
  endtask

  initial begin
    $display("[TB] conv_filter bench start, IMAGE_WIDTH=%0d", W);
    test_reset();
    test_border();
    test_row_gradient();
    test_exact_division();
    test_valid_gating();
    test_multi_frame();
    test_reset_midstream();
    bus.valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_filter.md
Name: conv_filter

Overview:
- Streaming 3x3 box-average (mean) filter for 8-bit-per-channel RGB video in the vision pipeline.
- Each valid pixel arrives with its frame coordinates (x_in, y_in).
- Outputs the per-channel mean of the 3x3 window whose bottom-right corner is the current pixel, or passes the pixel through where the window is incomplete.
- Sits between the camera pixel stream and downstream colour-detection logic.

Parameters:
- IMAGE_WIDTH, 640, pixels per line; sets line-buffer depth, with valid x range 0..IMAGE_WIDTH-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid  input  1  qualifies r_in/g_in/b_in/x_in/y_in for this cycle.
- r_in  input  8  red component of the current pixel.
- g_in  input  8  green component.
- b_in  input  8  blue component.
- x_in  input  11  column of the current pixel, 0 at line start.
- y_in  input  11  row of the current pixel, 0 at frame start.
- r_out  output  8  filtered red, registered.
- g_out  output  8  filtered green, registered.
- b_out  output  8  filtered blue, registered.

Behaviour:
- One clock domain. Reset is asynchronous and active-high. While rst=1:
  - r_out/g_out/b_out = 0.
  - Column-sum registers are cleared.
  - Line-buffer contents need not be reset; the border rules below keep stale data from reaching the outputs.
- Two line buffers per channel, LB1 and LB2, each IMAGE_WIDTH x 8 bits and addressed by x_in:
  - LB1[x] holds the pixel at (x, y-1).
  - LB2[x] holds the pixel at (x, y-2).
  - Reads are combinational, so the value read is the pre-edge content.
- On a rising edge with valid=1 and x_in < IMAGE_WIDTH:
  - LB2[x_in] <= LB1[x_in].
  - LB1[x_in] <= current pixel.
- Column sum, per channel, 10 bits: colsum = in + LB1[x_in] + LB2[x_in].
  - Registered history: colsum_d1 <= colsum; colsum_d2 <= colsum_d1 (on valid).
- Window sum, 12 bits, max 2295: total = colsum + colsum_d1 + colsum_d2.
- Mean = floor(total/9), computed as (total*7282) >> 16, which is exact for 0..2295. The result is always 0..255, so no saturation is needed.
- Output register on a rising edge with valid=1:
  - If x_in >= 2, y_in >= 2 and x_in < IMAGE_WIDTH: out <= mean.
  - Otherwise (border or out-of-range pixel): out <= current input pixel, unchanged.
- Latency: the output reflects the pixel sampled at edge N immediately after edge N, i.e. one register stage.
- valid=0: no line-buffer writes, no column-history shift, outputs hold.
- Line and frame boundaries need no explicit signal; x_in/y_in reset to 0 implicitly restart the window.
  - Column history from the previous line's tail is used only for x_in >= 2, by which point it has been replaced by the current line's columns.
- x_in >= IMAGE_WIDTH: no line-buffer write, column history still shifts, output = pass-through.
- Reset asserted mid-frame: outputs go to 0 immediately.
  - After release, filtering resumes correctly only once two full lines have been seen, i.e. from y_in >= 2.
- All three channels are independent and identical in datapath.

Test Plan:
- Reset: assert rst mid-stream with random pixels -> r/g/b_out = 0 asynchronously (before the next edge) and stay 0 while rst=1.
- Border pass-through: frame of random pixels -> for every pixel with x<2 or y<2, the output after its edge equals that input pixel exactly.
- Row gradient: row 0 all (10,10,10), row 1 all (20,20,20), row 2 all (30,30,30) -> at y=2, x>=2 the output is (20,20,20).
- Exact division: window sum 2295 (all 255) -> 255; window of values 0..8 (sum 36) -> 4; sum 35 -> 3. Apply to R, G and B with different values to check channel independence.
- valid gating: drop valid for 3 cycles mid-line with changing inputs -> outputs and line buffers unchanged. When valid returns, the next outputs match a golden model that ignores the dropped cycles.
- Multi-frame random: 5 frames, IMAGE_WIDTH=50, random RGB -> every output matches a software golden model (floor 3x3 mean or pass-through) with zero mismatches.
